// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the multi-port register file
//
// Contents:
//   state_t    : sweep FSM states (CLEAR, RUN)
//   XLEN_DEF   : default data width
//   ADDR_W_DEF : default register address width
//   REG_A0/A5/A7 : ABI register indices used as tap/event defaults

package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 5;

    localparam int REG_A0 = 10;
    localparam int REG_A5 = 15;
    localparam int REG_A7 = 17;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write bits with set-over-clear priority and NREAD lookups
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (clears all bits)
//   set_en/addr  : mark a destination pending (issue)
//   clr_en/addr  : clear a destination (writeback)
//   lookup_addr  : NREAD packed read addresses
//   lookup_busy  : NREAD registered pending bits, one per lookup address

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    set_en,
    input  logic [ADDR_W-1:0]       set_addr,
    input  logic                    clr_en,
    input  logic [ADDR_W-1:0]       clr_addr,
    input  logic [NREAD*ADDR_W-1:0] lookup_addr,
    output logic [NREAD-1:0]        lookup_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] bits;
    logic [DEPTH-1:0] bits_next;

    // Clear is applied first so a same-address set in the same cycle wins.
    // x0 never carries a pending write.
    always_comb begin
        bits_next = bits;
        if (clr_en) begin
            bits_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            bits_next[set_addr] = 1'b1;
        end
        bits_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bits <= '0;
        end else begin
            bits <= bits_next;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_lookup
        assign lookup_busy[g] = bits[lookup_addr[g*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port integer register file with clear sweep, scoreboard, taps and event register
//
// Optional feature: REGFILE_BYPASS_EN (same-cycle write/evt forwarding onto read ports and busy masking).
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (restarts the clear sweep)
//   ready      : high once every register x1..xN has been swept to zero
//   rd_addr    : NREAD packed read addresses
//   rd_data    : NREAD packed combinational read data (0 while !ready)
//   rd_busy    : NREAD pending-write flags (0 while !ready)
//   wr_en/addr/data : writeback port
//   sb_set/sb_addr  : issue-time pending mark
//   evt        : writes 1 to EVT_IDX, beats a same-cycle writeback there
//   tap0, tap1 : unbypassed contents of TAP0_IDX / TAP1_IDX (0 while !ready)

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = 2,
    parameter int TAP0_IDX = REG_A0,
    parameter int TAP1_IDX = REG_A5,
    parameter int EVT_IDX  = REG_A7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    ready,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    input  logic                    sb_set,
    input  logic [ADDR_W-1:0]       sb_addr,
    input  logic                    evt,
    output logic [XLEN-1:0]         tap0,
    output logic [XLEN-1:0]         tap1
);

    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] EVT_A  = ADDR_W'(EVT_IDX);
    localparam logic [ADDR_W-1:0] TAP0_A = ADDR_W'(TAP0_IDX);
    localparam logic [ADDR_W-1:0] TAP1_A = ADDR_W'(TAP1_IDX);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;

    logic [XLEN-1:0]   mem [DEPTH];

    logic              wr_go;
    logic              evt_go;
    logic              sb_go;
    logic [NREAD-1:0]  sb_busy;

    assign ready  = (state == RUN);

    // All update requests are dropped until the sweep has finished.
    assign wr_go  = ready && wr_en && (wr_addr != '0);
    assign evt_go = ready && evt && (EVT_A != '0);
    assign sb_go  = ready && sb_set && (sb_addr != '0);

    // ---------------------------------------------------------------
    // Clear sweep FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            idx   <= ADDR_W'(1);
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            CLEAR: begin
                idx_next = idx + 1'b1;
                if (idx == LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Register array: sweep writes in CLEAR, writeback/evt in RUN.
    // x0 is never written; reads of x0 are masked instead.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[idx] <= '0;
            end else begin
                if (wr_go && !(evt_go && (wr_addr == EVT_A))) begin
                    mem[wr_addr] <= wr_data;
                end
                if (evt_go) begin
                    mem[EVT_A] <= XLEN'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------
    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREAD  (NREAD)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (sb_go),
        .set_addr    (sb_addr),
        .clr_en      (ready && wr_en),
        .clr_addr    (wr_addr),
        .lookup_addr (rd_addr),
        .lookup_busy (sb_busy)
    );

    // ---------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------
    for (genvar g = 0; g < NREAD; g++) begin : g_read
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
        logic              busy;

        assign addr = rd_addr[g*ADDR_W +: ADDR_W];

        always_comb begin
            data = '0;
            if (ready && (addr != '0)) begin
                data = mem[addr];
`ifdef REGFILE_BYPASS_EN
                if (wr_go && (wr_addr == addr)) begin
                    data = wr_data;
                end
                // evt overrides a colliding writeback, matching the array update.
                if (evt_go && (addr == EVT_A)) begin
                    data = XLEN'(1);
                end
`endif
            end
        end

        always_comb begin
            busy = ready && sb_busy[g];
`ifdef REGFILE_BYPASS_EN
            if (wr_go && (wr_addr == addr) && !(sb_go && (sb_addr == addr))) begin
                busy = 1'b0;
            end
`endif
        end

        assign rd_data[g*XLEN +: XLEN] = data;
        assign rd_busy[g]              = busy;
    end

    // Taps observe the array directly, with no forwarding.
    assign tap0 = (ready && (TAP0_A != '0)) ? mem[TAP0_A] : '0;
    assign tap1 = (ready && (TAP1_A != '0)) ? mem[TAP1_A] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp

module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int AW     = 5;
    localparam int NREAD  = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  ready;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  sb_set;
    logic [AW-1:0]         sb_addr;
    logic                  evt;
    logic [XLEN-1:0]       tap0;
    logic [XLEN-1:0]       tap1;

    regfile_mp #(
        .XLEN   (XLEN),
        .ADDR_W (AW),
        .NREAD  (NREAD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ready   (ready),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .evt     (evt),
        .tap0    (tap0),
        .tap1    (tap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt;

    task automatic expect_val(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL queue_empty observed=%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fillv(input int a);
        return 32'h5A00_0000 | 32'(a);
    endfunction

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            rd_addr = {AW'(a), AW'(a)};
            #1;
            expect_val({tag, "_data"}, 64'd0);
            check(rd_data);
            expect_val({tag, "_busy"}, 64'd0);
            check(64'(rd_busy));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        rd_addr = {AW'(17), AW'(5)};
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
        evt     = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        expect_val("reset_ready", 64'd0);
        check(64'(ready));
        expect_val("reset_rd_data", 64'd0);
        check(rd_data);
        expect_val("reset_taps", 64'd0);
        check({tap0, tap1});

        // Sweep: count edges until ready
        rst_n = 1'b1;
        cnt   = 0;
        while (!ready && cnt < 100) begin
            expect_val("sweep_rd_data", 64'd0);
            check(rd_data);
            expect_val("sweep_taps", 64'd0);
            check({tap0, tap1});
            expect_val("sweep_busy", 64'd0);
            check(64'(rd_busy));
            tick();
            cnt++;
        end
        expect_val("sweep_edges", 64'd31);
        check(64'(cnt));
        read_all_zero("post_sweep");

        // Write/read x5 on both ports
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hDEADBEEF;
        rd_addr = {AW'(5), AW'(5)};
        #1;
`ifdef REGFILE_BYPASS_EN
        expect_val("bypass_x5", {32'hDEADBEEF, 32'hDEADBEEF});
`else
        expect_val("nobypass_x5_old", 64'd0);
`endif
        check(rd_data);
        tick();
        wr_en = 1'b0;
        #1;
        expect_val("read_x5", {32'hDEADBEEF, 32'hDEADBEEF});
        check(rd_data);

        // Write to x0 is discarded
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'h1234;
        tick();
        wr_en   = 1'b0;
        rd_addr = {AW'(0), AW'(0)};
        #1;
        expect_val("read_x0", 64'd0);
        check(rd_data);

        // evt beats writeback on x17
        wr_en   = 1'b1;
        wr_addr = 5'd17;
        wr_data = 32'hAAAA;
        evt     = 1'b1;
        tick();
        wr_en   = 1'b0;
        evt     = 1'b0;
        rd_addr = {AW'(17), AW'(17)};
        #1;
        expect_val("evt_x17", {32'd1, 32'd1});
        check(rd_data);

        // Taps
        wr_en   = 1'b1;
        wr_addr = 5'd10;
        wr_data = 32'd7;
        tick();
        wr_addr = 5'd15;
        wr_data = 32'd9;
        tick();
        wr_en = 1'b0;
        #1;
        expect_val("taps", {32'd7, 32'd9});
        check({tap0, tap1});

        // Scoreboard
        sb_set  = 1'b1;
        sb_addr = 5'd3;
        tick();
        sb_set  = 1'b0;
        rd_addr = {AW'(0), AW'(3)};
        #1;
        expect_val("sb_set_x3", 64'd1);
        check(64'(rd_busy));
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h33;
        sb_set  = 1'b1;
        sb_addr = 5'd3;
        tick();
        sb_set = 1'b0;
        wr_en  = 1'b0;
        #1;
        expect_val("sb_set_wins", 64'd1);
        check(64'(rd_busy));
        expect_val("x3_data", {32'd0, 32'h33});
        check(rd_data);
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h44;
        tick();
        wr_en = 1'b0;
        #1;
        expect_val("sb_clear_x3", 64'd0);
        check(64'(rd_busy));
        sb_set  = 1'b1;
        sb_addr = 5'd0;
        tick();
        sb_set  = 1'b0;
        rd_addr = {AW'(0), AW'(0)};
        #1;
        expect_val("sb_x0_never", 64'd0);
        check(64'(rd_busy));

        // Fill and reset mid-stream
        for (int a = 1; a < 32; a++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(a);
            wr_data = fillv(a);
            sb_set  = 1'b1;
            sb_addr = AW'(a);
            if (a == 16) begin
                rd_addr = {AW'(1), AW'(1)};
                #1;
                expect_val("fill_x1", {fillv(1), fillv(1)});
                check(rd_data);
                rst_n = 1'b0;
            end
            tick();
            if (a == 16) begin
                rst_n = 1'b1;
                expect_val("midrun_ready_drop", 64'd0);
                check(64'(ready));
                break;
            end
        end

        cnt = 0;
        while (cnt < 100) begin
            wr_en   = 1'b1;
            wr_addr = AW'((cnt % 31) + 1);
            wr_data = 32'hFFFF_0000 | 32'(cnt);
            evt     = 1'b1;
            sb_set  = 1'b1;
            sb_addr = AW'((cnt % 31) + 1);
            rd_addr = {AW'(17), AW'((cnt % 31) + 1)};
            #1;
            expect_val("resweep_rd_data", 64'd0);
            check(rd_data);
            expect_val("resweep_busy", 64'd0);
            check(64'(rd_busy));
            tick();
            cnt++;
            if (ready) break;
        end
        wr_en  = 1'b0;
        evt    = 1'b0;
        sb_set = 1'b0;
        expect_val("resweep_edges", 64'd31);
        check(64'(cnt));
        read_all_zero("post_resweep");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
